muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001: Parameter WIDTH, default 32, SHALL set the operand width and the HI/LO width; legal values are even and >= 4.
REQ-002: clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003: rst  input  1  synchronous, active-high reset.
REQ-004: start  input  1  request to begin the operation selected by op.
REQ-005: op  input  2  operation select: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
REQ-006: a  input  WIDTH  multiplicand or dividend.
REQ-007: b  input  WIDTH  multiplier or divisor.
REQ-008: hi_we  input  1  direct write enable for HI (mthi).
REQ-009: lo_we  input  1  direct write enable for LO (mtlo).
REQ-010: hi_wd  input  WIDTH  direct write data for HI.
REQ-011: lo_wd  input  WIDTH  direct write data for LO.
REQ-012: busy  output  1  unit occupied; the pipeline stalls on any mfhi/mflo/start while busy=1.
REQ-013: done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
REQ-014: div_by_zero  output  1  qualifies done: the completed divide had b=0.
REQ-015: hi  output  WIDTH  HI register (product upper half or remainder).
REQ-016: lo  output  WIDTH  LO register (product lower half or quotient).

Function
REQ-017: FSM states: IDLE, RUN, FIX; IDLE->RUN when start=1 in IDLE; RUN->FIX after exactly WIDTH iterations; FIX->IDLE unconditionally.
REQ-018: The edge at which start is sampled in IDLE is edge 0; operands, op, and the operand signs SHALL be captured at edge 0; later changes to a/b/op SHALL have no effect.
REQ-019: busy SHALL be 1 from edge 0 through edge WIDTH+1 inclusive (WIDTH+1 cycles), and 0 otherwise.
REQ-020: RUN SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per cycle on magnitudes, using a down-counter of ceil(log2(WIDTH+1)) bits.
REQ-021: At edge WIDTH+1 (FIX), HI/LO SHALL be loaded with the sign-corrected result, done SHALL be 1 for exactly the following cycle, and busy SHALL be 0 in that same cycle.
REQ-022: mult/multu: {hi,lo} SHALL equal the exact 2*WIDTH-bit two's-complement (mult) or unsigned (multu) product.
REQ-023: div/divu: lo = quotient, hi = remainder; signed quotient truncates toward zero; signed remainder takes the sign of the dividend; |remainder| < |divisor|.
REQ-024: Divide with b=0 (either signedness): hi=a, lo=all ones, div_by_zero=1 with done; latency SHALL be unchanged.
REQ-025: div with a = most-negative and b = -1: lo = most-negative, hi = 0, div_by_zero = 0.
REQ-026: div_by_zero SHALL be 0 whenever done=0.
REQ-027: start while busy=1 SHALL be ignored (no queueing, no restart).
REQ-028: hi_we/lo_we while busy=1 SHALL be ignored; in IDLE they SHALL write hi_wd/lo_wd at the next edge; hi_we and lo_we in the same cycle SHALL both take effect.
REQ-029: start and hi_we/lo_we in the same IDLE cycle: start wins, and the direct write is dropped.
REQ-030: HI/LO SHALL hold their value in all cycles other than a FIX load, a permitted direct write, or reset.

Reset
REQ-031: rst=1 at an edge SHALL force state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, regardless of state.
REQ-032: Reset mid-operation SHALL abandon the operation with no later done pulse; start SHALL be ignored while rst=1.

Verification (WIDTH=32)
REQ-033: mult a=0xFFFFFFFD, b=7 -> busy 33 cycles, then done with hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034: multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; second start during busy ignored (exactly one done).
REQ-035: div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=2 -> lo=3, hi=1.
REQ-036: div a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 for the done cycle only; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037: rst asserted 10 cycles after start -> next cycle busy=0, hi=lo=0, no done within 40 cycles; then mtlo lo_wd=0x1234 in IDLE -> lo=0x1234 next cycle, hi unchanged.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Works on operand magnitudes, one shift-add or restoring shift-subtract step per cycle, then sign-fixes.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_wd,
    input  logic [WIDTH-1:0] lo_wd,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q, a_q, hi_q, lo_q;
    logic             is_div_q, neg_q_q, neg_r_q, b_zero_q;
    logic             busy_q, done_q, dbz_q;

    logic [WIDTH-1:0]   acc_hi_d, acc_lo_d;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, a_mag, b_mag;
    logic               sgn_in;

    always_comb begin
        sgn_in    = ~op[0];
        a_mag     = (sgn_in && a[WIDTH-1]) ? -a : a;
        b_mag     = (sgn_in && b[WIDTH-1]) ? -b : b;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        acc_hi_d  = mul_sum[WIDTH:1];
        acc_lo_d  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        if (is_div_q) begin
            // Remainder stays below the divisor, so bit WIDTH of the difference is the borrow.
            if (!div_diff[WIDTH]) begin
                acc_hi_d = div_diff[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_hi_d = div_shift[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end
        prod_fix = neg_q_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
        quo_fix  = neg_q_q ? -acc_lo_q : acc_lo_q;
        rem_fix  = neg_r_q ? -acc_hi_q : acc_hi_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            b_zero_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        busy_q   <= 1'b1;
                        cnt_q    <= CNT_INIT;
                        acc_hi_q <= '0;
                        acc_lo_q <= a_mag;
                        opb_q    <= b_mag;
                        a_q      <= a;
                        is_div_q <= op[1];
                        neg_q_q  <= sgn_in & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_q  <= sgn_in & a[WIDTH-1];
                        b_zero_q <= (b == '0);
                    end else begin
                        if (hi_we) hi_q <= hi_wd;
                        if (lo_we) lo_q <= lo_wd;
                    end
                end
                RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= FIX;
                end
                FIX: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_fix;
                    end else if (b_zero_q) begin
                        hi_q  <= a_q;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an arithmetic model,
// and hand-written sequences for reset, direct writes and ignored starts.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         hi_we = 1'b0, lo_we = 1'b0;
    logic [W-1:0] hi_wd = '0, lo_wd = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wd(hi_wd), .lo_wd(lo_wd),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, ehi, elo;
        logic         edbz;
        int           inject;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic straight from the operation definitions.
    task automatic model(input logic [1:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] rhi, output logic [W-1:0] rlo, output logic rdbz);
        longint sa, sb, q, r;
        logic [63:0] p, ua, ub;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        ua = {32'b0, ia};
        ub = {32'b0, ib};
        rdbz = 1'b0;
        case (o)
            2'b00: begin p = 64'(sa * sb); rhi = p[63:32]; rlo = p[31:0]; end
            2'b01: begin p = ua * ub;      rhi = p[63:32]; rlo = p[31:0]; end
            default: begin
                if (ib == '0) begin
                    rhi = ia; rlo = '1; rdbz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    rhi = W'(r); rlo = W'(q);
                end else begin
                    p = ua / ub; rlo = p[31:0];
                    p = ua % ub; rhi = p[31:0];
                end
            end
        endcase
    endtask

    // inject: 0 plain, 1 extra start mid-busy, 2 direct writes with start and mid-busy.
    task automatic do_op(input string nm, input logic [1:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edbz, input int inject);
        logic [W-1:0] prev_hi, prev_lo;
        int  bcnt, extra;
        logic hold_ok;
        @(negedge clk);
        prev_hi = hi; prev_lo = lo;
        op = o; a = ia; b = ib; start = 1'b1;
        if (inject == 2) begin hi_we = 1'b1; lo_we = 1'b1; hi_wd = 32'hDEADBEEF; lo_wd = 32'hCAFEF00D; end
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        bcnt = 0; hold_ok = 1'b1;
        while (busy === 1'b1 && bcnt < 100) begin
            bcnt++;
            if (hi !== prev_hi || lo !== prev_lo || done !== 1'b0) hold_ok = 1'b0;
            start = (inject == 1 && bcnt == 5);
            hi_we = (inject == 2 && bcnt == 3);
            lo_we = hi_we;
            hi_wd = $urandom; lo_wd = $urandom;
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0b done=%0b busy_cycles=%0d",
                 o, ia, ib, hi, lo, div_by_zero, done, bcnt);
        check({nm, " busy_cycles"}, 64'(bcnt), 64'(W + 1));
        check({nm, " done"}, {63'b0, done}, 64'd1);
        check({nm, " hi"}, {32'b0, hi}, {32'b0, ehi});
        check({nm, " lo"}, {32'b0, lo}, {32'b0, elo});
        check({nm, " dbz"}, {63'b0, div_by_zero}, {63'b0, edbz});
        check({nm, " hold_while_busy"}, {63'b0, hold_ok}, 64'd1);
        @(negedge clk);
        check({nm, " pulse_end"}, {62'b0, done, div_by_zero}, 64'd0);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(negedge clk);
        end
        check({nm, " no_extra_op"}, 64'(extra), 64'd0);
        check({nm, " result_held"}, {hi, lo}, {ehi, elo});
    endtask

    initial begin
        logic [W-1:0] rhi, rlo, ra, rb;
        logic [1:0]   ro;
        logic         rdbz;
        int           dcnt;

        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1};
        vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0};
        vecs[3] = '{2'b11, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 2};
        vecs[4] = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 0};
        vecs[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0};
        vecs[6] = '{2'b11, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0};
        vecs[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0};
        vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 0};
        vecs[9] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 2};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_outputs", {29'b0, busy, done, div_by_zero, hi, lo}, 64'd0);
        check("reset_hi", {32'b0, hi}, 64'd0);

        for (int i = 0; i < 10; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].ehi, vecs[i].elo, vecs[i].edbz, vecs[i].inject);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            model(ro, ra, rb, rhi, rlo, rdbz);
            do_op($sformatf("rand%0d", i), ro, ra, rb, rhi, rlo, rdbz, 0);
        end

        // Simultaneous direct writes in IDLE.
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b1; hi_wd = 32'hAAAA5555; lo_wd = 32'h1234ABCD;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);
        check("direct_write_both", {hi, lo}, {32'hAAAA5555, 32'h1234ABCD});

        // Reset mid-operation, with start held during reset.
        op = 2'b10; a = 32'd100; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        $display("reset mid-op -> busy=%0b hi=%h lo=%h", busy, hi, lo);
        check("midop_reset_state", {31'b0, busy, hi}, 64'd0);
        check("midop_reset_lo", {32'b0, lo}, 64'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcnt++;
            @(negedge clk);
        end
        check("no_done_after_reset", 64'(dcnt), 64'd0);
        lo_we = 1'b1; lo_wd = 32'h00001234;
        @(negedge clk);
        lo_we = 1'b0;
        $display("mtlo -> hi=%h lo=%h", hi, lo);
        check("mtlo_after_reset", {hi, lo}, {32'h0, 32'h00001234});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
